// File: rtl/rv_req_responder.sv
// Memory-side endpoint of the toggle req/ack channel: turns each new request
// into one valid/ready backend transfer, with a watchdog so the initiator never hangs.
module rv_req_responder #(
  parameter int ADDR_WIDTH = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rv_req,
  output logic                  rv_req_ack,
  input  logic [ADDR_WIDTH-1:0] rv_addr,
  input  logic [15:0]           rv_din,
  input  logic [1:0]            rv_ds,
  input  logic                  rv_we,
  output logic [15:0]           rv_dout,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_be,
  input  logic                  mem_rvalid,
  input  logic [15:0]           mem_rdata,
  output logic                  err,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [15:0]           dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            be_q, be_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;

  logic pending, maskedWrite, expired;

  assign pending     = rv_req ^ ack_q;
  assign maskedWrite = rv_we && (rv_ds == 2'b00);
  // The counter tracks cycles already spent in the state, so the edge that
  // completes the TIMEOUT-th cycle is the abandon edge.
  assign expired     = (cnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dout_q  <= 16'h0000;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pending && !maskedWrite) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_ready)    state_d = we_q ? IDLE : WAIT_RD;
        else if (expired) state_d = IDLE;
      end
      WAIT_RD: begin
        if (mem_rvalid || expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic timeoutEvt;
    timeoutEvt = 1'b0;
    ack_d      = ack_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (pending) begin
          we_d    = rv_we;
          addr_d  = rv_addr;
          wdata_d = rv_din;
          be_d    = rv_ds;
          if (maskedWrite) begin
            ack_d = ~ack_q;
          end else begin
            valid_d = 1'b1;
            cnt_d   = 16'h0000;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          cnt_d   = 16'h0000;
          if (we_q) ack_d = ~ack_q;
        end else if (expired) begin
          timeoutEvt = 1'b1;
          valid_d    = 1'b0;
          ack_d      = ~ack_q;
          if (!we_q) dout_d = 16'hDEAD;
        end else begin
          cnt_d = cnt_q + 16'h0001;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          dout_d = mem_rdata;
          ack_d  = ~ack_q;
        end else if (expired) begin
          timeoutEvt = 1'b1;
          dout_d     = 16'hDEAD;
          ack_d      = ~ack_q;
        end else begin
          cnt_d = cnt_q + 16'h0001;
        end
      end
      default: ;
    endcase
    // A timeout in the same cycle as a clear must still leave the flag set.
    err_d = err_q;
    if (err_clr)    err_d = 1'b0;
    if (timeoutEvt) err_d = 1'b1;
  end

  assign rv_req_ack = ack_q;
  assign rv_dout    = dout_q;
  assign mem_valid  = valid_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rv_req_responder.sv
// Directed bench for rv_req_responder: writes, stalled reads, masked writes,
// watchdog timeouts and back-to-back reads, with hand-computed expectations.
module tb_rv_req_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rv_req;
  logic        rv_req_ack;
  logic [19:0] rv_addr;
  logic [15:0] rv_din;
  logic [1:0]  rv_ds;
  logic        rv_we;
  logic [15:0] rv_dout;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        err;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;

  rv_req_responder #(.ADDR_WIDTH(20), .TIMEOUT(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rv_req     (rv_req),
    .rv_req_ack (rv_req_ack),
    .rv_addr    (rv_addr),
    .rv_din     (rv_din),
    .rv_ds      (rv_ds),
    .rv_we      (rv_we),
    .rv_dout    (rv_dout),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit so outputs are sampled away from it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    rv_req     = 1'b0;
    rv_addr    = 20'h0;
    rv_din     = 16'h0;
    rv_ds      = 2'b00;
    rv_we      = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    err_clr    = 1'b0;
    repeat (3) applyStimulus();

    // Reset state
    checkOutput("rst_ack",   32'(rv_req_ack), 32'h0);
    checkOutput("rst_dout",  32'(rv_dout),    32'h0);
    checkOutput("rst_valid", 32'(mem_valid),  32'h0);
    checkOutput("rst_we",    32'(mem_we),     32'h0);
    checkOutput("rst_addr",  32'(mem_addr),   32'h0);
    checkOutput("rst_wdata", 32'(mem_wdata),  32'h0);
    checkOutput("rst_be",    32'(mem_be),     32'h0);
    checkOutput("rst_err",   32'(err),        32'h0);
    resetn = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("idle_no_valid", 32'(mem_valid), 32'h0);

    $display("[TB] write with immediate ready");
    rv_req = 1'b1; rv_addr = 20'h33000; rv_din = 16'hA55A; rv_ds = 2'b10; rv_we = 1'b1;
    mem_ready = 1'b1;
    applyStimulus();
    checkOutput("wr_valid_e0", 32'(mem_valid),  32'h1);
    checkOutput("wr_be",       32'(mem_be),     32'h2);
    checkOutput("wr_wdata",    32'(mem_wdata),  32'hA55A);
    checkOutput("wr_addr",     32'(mem_addr),   32'h33000);
    checkOutput("wr_we",       32'(mem_we),     32'h1);
    checkOutput("wr_ack_e0",   32'(rv_req_ack), 32'h0);
    applyStimulus();
    checkOutput("wr_valid_e1", 32'(mem_valid),  32'h0);
    checkOutput("wr_ack_e1",   32'(rv_req_ack), 32'h1);
    mem_ready = 1'b0;
    applyStimulus();
    checkOutput("wr_no_reissue", 32'(mem_valid), 32'h0);

    $display("[TB] read with 3-cycle ready stall");
    rv_req = 1'b0; rv_addr = 20'h00010; rv_din = 16'hFFFF; rv_ds = 2'b11; rv_we = 1'b0;
    applyStimulus();
    checkOutput("rd_valid_e0", 32'(mem_valid), 32'h1);
    checkOutput("rd_we",       32'(mem_we),    32'h0);
    rv_addr = 20'hFFFFF; rv_ds = 2'b00; rv_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("rd_stall_valid", 32'(mem_valid), 32'h1);
      checkOutput("rd_stall_addr",  32'(mem_addr),  32'h00010);
      checkOutput("rd_stall_be",    32'(mem_be),    32'h3);
      checkOutput("rd_stall_we",    32'(mem_we),    32'h0);
    end
    mem_ready = 1'b1;
    applyStimulus();
    checkOutput("rd_accept_valid", 32'(mem_valid),  32'h0);
    checkOutput("rd_accept_ack",   32'(rv_req_ack), 32'h1);
    mem_ready = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("rd_wait_ack",  32'(rv_req_ack), 32'h1);
    checkOutput("rd_wait_dout", 32'(rv_dout),    32'h0);
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    applyStimulus();
    checkOutput("rd_dout_at_ack", 32'(rv_dout),    32'h1234);
    checkOutput("rd_ack",         32'(rv_req_ack), 32'h0);
    mem_rvalid = 1'b0; mem_rdata = 16'h0000;

    $display("[TB] write after read keeps rv_dout");
    rv_req = 1'b1; rv_addr = 20'h00005; rv_din = 16'h0F0F; rv_ds = 2'b01; rv_we = 1'b1;
    mem_ready = 1'b1;
    applyStimulus();
    checkOutput("wr2_be", 32'(mem_be), 32'h1);
    applyStimulus();
    checkOutput("wr2_ack",       32'(rv_req_ack), 32'h1);
    checkOutput("wr2_dout_held", 32'(rv_dout),    32'h1234);
    mem_ready = 1'b0;
    applyStimulus();

    $display("[TB] masked write");
    rv_req = 1'b0; rv_ds = 2'b00; rv_we = 1'b1; rv_din = 16'h5555;
    applyStimulus();
    checkOutput("mw_ack_e0", 32'(rv_req_ack), 32'h0);
    checkOutput("mw_valid",  32'(mem_valid),  32'h0);
    applyStimulus();
    checkOutput("mw_valid_after", 32'(mem_valid), 32'h0);

    $display("[TB] read timeout");
    rv_req = 1'b1; rv_addr = 20'h00100; rv_ds = 2'b11; rv_we = 1'b0;
    applyStimulus();
    checkOutput("to_valid_e0", 32'(mem_valid), 32'h1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
      checkOutput("to_pending_ack", 32'(rv_req_ack), 32'h0);
      checkOutput("to_pending_valid", 32'(mem_valid), 32'h1);
    end
    applyStimulus();
    checkOutput("to_ack",   32'(rv_req_ack), 32'h1);
    checkOutput("to_valid", 32'(mem_valid),  32'h0);
    checkOutput("to_dout",  32'(rv_dout),    32'hDEAD);
    checkOutput("to_err",   32'(err),        32'h1);
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; mem_ready = 1'b1;
    applyStimulus();
    checkOutput("late_dout",  32'(rv_dout),    32'hDEAD);
    checkOutput("late_ack",   32'(rv_req_ack), 32'h1);
    checkOutput("late_valid", 32'(mem_valid),  32'h0);
    mem_rvalid = 1'b0; mem_rdata = 16'h0000; mem_ready = 1'b0;
    applyStimulus();
    checkOutput("err_sticky", 32'(err), 32'h1);

    $display("[TB] write timeout with coincident err_clr");
    rv_req = 1'b0; rv_addr = 20'h00200; rv_din = 16'h7777; rv_ds = 2'b11; rv_we = 1'b1;
    applyStimulus();
    repeat (7) applyStimulus();
    checkOutput("to2_ack_pending", 32'(rv_req_ack), 32'h1);
    err_clr = 1'b1;
    applyStimulus();
    checkOutput("to2_ack",      32'(rv_req_ack), 32'h0);
    checkOutput("to2_err_wins", 32'(err),        32'h1);
    checkOutput("to2_dout",     32'(rv_dout),    32'hDEAD);
    applyStimulus();
    checkOutput("err_cleared", 32'(err), 32'h0);
    err_clr = 1'b0;

    $display("[TB] back-to-back reads");
    rv_req = 1'b1; rv_addr = 20'h00200; rv_we = 1'b0; rv_ds = 2'b11;
    mem_ready = 1'b1;
    applyStimulus();
    checkOutput("b2b0_valid", 32'(mem_valid), 32'h1);
    checkOutput("b2b0_addr",  32'(mem_addr),  32'h00200);
    applyStimulus();
    checkOutput("b2b0_accept", 32'(mem_valid), 32'h0);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
    applyStimulus();
    checkOutput("b2b0_dout", 32'(rv_dout),    32'h1111);
    checkOutput("b2b0_ack",  32'(rv_req_ack), 32'h1);
    rv_req = 1'b0; rv_addr = 20'h00201; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    mem_ready = 1'b1;
    applyStimulus();
    checkOutput("b2b1_valid", 32'(mem_valid), 32'h1);
    checkOutput("b2b1_addr",  32'(mem_addr),  32'h00201);
    checkOutput("b2b1_dout_held", 32'(rv_dout), 32'h1111);
    applyStimulus();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h2222;
    applyStimulus();
    checkOutput("b2b1_dout", 32'(rv_dout),    32'h2222);
    checkOutput("b2b1_ack",  32'(rv_req_ack), 32'h0);
    mem_rvalid = 1'b0;
    applyStimulus();
    checkOutput("b2b_idle", 32'(mem_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
